// File: rtl/an_encoder_seq.sv
// Sequential AN-code encoder: forms A*x by shift-and-add, one bit of A per cycle,
// then XORs an injection mask into the codeword and holds it for the consumer.
module an_encoder_seq #(
    parameter int unsigned A      = 13,
    parameter int unsigned A_W    = 4,
    parameter int unsigned DATA_W = 3,
    parameter int unsigned CODE_W = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CODE_W-1:0] in_mask_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CODE_W-1:0] out_code_o,
    output logic              out_range_err_o
);

    localparam int unsigned    AccW    = DATA_W + A_W;
    localparam int unsigned    CntW    = (A_W > 1) ? $clog2(A_W) : 1;
    localparam logic [A_W-1:0] AVec    = A[A_W-1:0];
    localparam logic [CntW-1:0] CntLast = CntW'(A_W - 1);

    typedef enum logic [1:0] {StIdle, StMul, StHold} state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [AccW-1:0]   x_q;
    logic [AccW-1:0]   acc_q;
    logic [AccW-1:0]   acc_d;
    logic [CODE_W-1:0] mask_q;
    logic [CODE_W-1:0] out_code_q;
    logic [CODE_W-1:0] out_code_d;
    logic              out_range_err_q;
    logic              out_range_err_d;

    // x_q is pre-shifted each cycle, so adding it directly is acc + (x << i).
    always_comb begin
        acc_d = acc_q;
        if (AVec[cnt_q]) begin
            acc_d = acc_q + x_q;
        end
        out_code_d      = acc_d[CODE_W-1:0] ^ mask_q;
        out_range_err_d = |(acc_d >> CODE_W);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= StIdle;
            cnt_q           <= '0;
            x_q             <= '0;
            acc_q           <= '0;
            mask_q          <= '0;
            out_code_q      <= '0;
            out_range_err_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid_i) begin
                        x_q     <= AccW'(in_data_i);
                        mask_q  <= in_mask_i;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= StMul;
                    end
                end
                StMul: begin
                    acc_q <= acc_d;
                    x_q   <= x_q << 1;
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == CntLast) begin
                        out_code_q      <= out_code_d;
                        out_range_err_q <= out_range_err_d;
                        state_q         <= StHold;
                    end
                end
                StHold: begin
                    if (out_ready_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready_o      = (state_q == StIdle);
    assign out_valid_o     = (state_q == StHold);
    assign out_code_o      = out_code_q;
    assign out_range_err_o = out_range_err_q;

endmodule

// File: tb/tb_an_encoder_seq.sv
// Bench for an_encoder_seq: directed and random words against an arithmetic model,
// plus a behavioural single-error-correcting A=13 decoder for loopback.
module tb_an_encoder_seq;

    localparam int A  = 13;
    localparam int CW = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_data = '0;
    logic [5:0] in_mask = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [5:0] out_code;
    logic       out_range_err;

    int n_cmp  = 0;
    int n_fail = 0;

    an_encoder_seq dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .in_data_i      (in_data),
        .in_mask_i      (in_mask),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_code_o     (out_code),
        .out_range_err_o(out_range_err)
    );

    always #5 clk = ~clk;

    function automatic int ref_code(input int x, input int m);
        return ((A * x) % (1 << CW)) ^ m;
    endfunction

    function automatic int ref_err(input int x);
        return ((A * x) > ((1 << CW) - 1)) ? 1 : 0;
    endfunction

    // Every single-bit flip of a 6-bit word has a distinct nonzero residue mod 13.
    function automatic void decode(input int code, output int q, output int err);
        q   = -1;
        err = 0;
        if (code % A == 0) begin
            q = code / A;
        end else begin
            err = 1;
            for (int k = 0; k < CW; k++) begin
                if (((code ^ (1 << k)) % A) == 0) q = (code ^ (1 << k)) / A;
            end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic accept(input int x, input int m);
        @(negedge clk);
        check("accept.ready", in_ready, 1);
        in_valid = 1'b1;
        in_data  = 3'(x);
        in_mask  = 6'(m);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 3'($urandom);
        in_mask  = 6'($urandom);
    endtask

    // Edges after the accept edge until out_valid, bounded.
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_word(input int x, input int m, input string tag, output int code);
        int n;
        accept(x, m);
        wait_valid(n);
        check({tag, ".latency"}, n, 4);
        check({tag, ".code"}, out_code, ref_code(x, m));
        check({tag, ".range_err"}, out_range_err, ref_err(x));
        code = int'(out_code);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".after_hs"}, {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        int n, code, q, err, m;
        int t[$];

        repeat (2) @(posedge clk);
        #1;
        check("reset.in_ready", in_ready, 1);
        check("reset.out_valid", out_valid, 0);
        check("reset.out_code", out_code, 0);
        check("reset.range_err", out_range_err, 0);
        rst = 1'b0;

        for (int x = 0; x <= 4; x++) run_word(x, 0, "clean", code);
        for (int x = 1; x <= 4; x++) run_word(x, 1, "inj1", code);
        run_word(1, 2, "inj_x1_m2", code);
        run_word(3, 8, "inj_x3_m8", code);
        run_word(5, 0, "range_x5", code);
        run_word(7, 1, "range_x7", code);

        // Backpressure with a pending word held on the input.
        accept(2, 0);
        wait_valid(n);
        check("bp.latency", n, 4);
        in_valid = 1'b1;
        in_data  = 3'd3;
        in_mask  = 6'd0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("bp.code", out_code, 26);
            check("bp.valid", out_valid, 1);
            check("bp.in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp.after_hs", {out_valid, in_ready}, 2'b01);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp.taken", in_ready, 0);
        wait_valid(n);
        check("bp.latency2", n, 4);
        check("bp.code2", out_code, 39);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Streaming throughput.
        in_valid  = 1'b1;
        in_data   = 3'd4;
        in_mask   = 6'd0;
        out_ready = 1'b1;
        for (int c = 0; c < 40 && t.size() < 3; c++) begin
            @(negedge clk);
            if (out_valid) begin
                t.push_back(c);
                check("tput.code", out_code, 52);
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("tput.count", t.size(), 3);
        if (t.size() == 3) begin
            check("tput.gap1", t[1] - t[0], 6);
            check("tput.gap2", t[2] - t[1], 6);
        end

        // Reset mid-operation drops the word.
        accept(4, 0);
        check("rst.mul_valid", out_valid, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst.in_ready", in_ready, 1);
        check("rst.out_valid", out_valid, 0);
        check("rst.out_code", out_code, 0);
        check("rst.range_err", out_range_err, 0);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check("rst.no_valid", out_valid, 0);
        end
        run_word(1, 0, "rst.fresh", code);

        // Decoder loopback with every single-bit mask.
        for (int x = 0; x <= 4; x++) begin
            for (int k = -1; k < CW; k++) begin
                m = (k < 0) ? 0 : (1 << k);
                run_word(x, m, "loop", code);
                decode(code, q, err);
                check("loop.q", q, x);
                check("loop.err", err, (m != 0) ? 1 : 0);
            end
        end

        // Random words, including multi-bit masks.
        for (int i = 0; i < 40; i++) begin
            int x, sel;
            x   = $urandom_range(0, 7);
            sel = $urandom_range(0, 2);
            m   = (sel == 0) ? 0 : (sel == 1) ? (1 << $urandom_range(0, 5)) : $urandom_range(0, 63);
            run_word(x, m, "rand", code);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/an_encoder_seq.md
# an_encoder_seq

Sequential AN-code encoder and the transmit end of the A=13 AN-coded datapath. It accepts a data word over a valid/ready handshake and forms the codeword A·x with a shift-and-add multiplier, one multiplier bit of A per cycle. It XORs an optional error-injection mask into the codeword and presents the result over a second valid/ready handshake. Its output feeds the Barrett-reduction AN decoder, as a functional source and as a controlled fault injector.

## Interface
- A, 13, AN-code constant; odd, 1 < A < 2^A_W
- A_W, 4, bit width of A; also the number of multiply cycles
- DATA_W, 3, data word width
- CODE_W, 6, codeword width seen by the decoder
- clk  in  1  rising-edge clock; the block uses one clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  in_data and in_mask are valid
- in_ready  out  1  encoder can accept a word
- in_data  in  DATA_W  data word x
- in_mask  in  CODE_W  error-injection mask XORed into the codeword; 0 means a clean codeword
- out_valid  out  1  out_code and out_range_err are valid
- out_ready  in  1  consumer accepts the output
- out_code  out  CODE_W  (A·x mod 2^CODE_W) XOR mask
- out_range_err  out  1  A·x > 2^CODE_W−1; the codeword is truncated

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - MUL: A_W iterations, counter i = 0..A_W−1.
  - HOLD: out_valid=1.
- IDLE → MUL on in_valid && in_ready:
  - latch x into a DATA_W+A_W-bit shift register.
  - latch in_mask into the mask register.
  - clear the accumulator (DATA_W+A_W bits) and set i=0.
- MUL, each cycle:
  - if A[i]=1, acc ← acc + (x << i). The add never overflows, because acc is DATA_W+A_W bits wide.
  - increment i.
  - after the iteration with i=A_W−1, go to HOLD.
- On entry to HOLD, register the outputs:
  - out_code = acc[CODE_W−1:0] ^ mask.
  - out_range_err = |acc[DATA_W+A_W−1:CODE_W] (OR of the acc bits above CODE_W).
- The mask never affects out_range_err.
- HOLD → IDLE on out_valid && out_ready. Outputs stay stable while out_ready=0, with no limit on the stall.
- No overlap: in_ready=0 in MUL and HOLD, so the block accepts one word at a time.
- in_data and in_mask are ignored outside the accept cycle.
- Reset:
  - the state goes to IDLE.
  - counter, accumulator, mask, out_code and out_range_err are cleared to 0.
  - out_valid is 0; in_ready reads 1 in the cycle after the reset edge.
- Reset mid-operation (in MUL or HOLD) drops the in-flight word. No output handshake occurs for it.
- rst has priority over every handshake in the same cycle.

## Timing
- in_ready and out_valid are decoded directly from the state register, with no combinational path from inputs.
- Accept at clock edge E0 → out_valid=1 after edge E(A_W). That is 4 cycles for A_W=4.
- Output handshake at edge Eh → out_valid=0 and in_ready=1 after Eh.
- The next word can be accepted at Eh+1 at the earliest.
- Maximum throughput is one word per A_W+2 cycles (6 for the default parameters).
- out_code and out_range_err change only on the edge entering HOLD, and on reset.
- in_valid held high while in_ready=0 is legal. The word is taken on the first edge at which in_ready=1.

## Test plan
- Clean codewords, one at a time:
  - stimulus: x=0,1,2,3,4 with mask=0 and out_ready=1.
  - required: out_code = 0, 13, 26, 39, 52 with out_range_err=0.
  - required: out_valid rises exactly 4 cycles after each accept.
- Single-bit injection:
  - stimulus: x=1,2,3,4 with mask=1.
  - required: out_code = 12, 27, 38, 53.
  - stimulus: x=1 with mask=2.
  - required: out_code = 15.
  - stimulus: x=3 with mask=8.
  - required: out_code = 47.
  - required: out_range_err=0 for all of these.
- Range overflow:
  - stimulus: x=5.
  - required: out_code=1 (65 mod 64) and out_range_err=1.
  - stimulus: x=7 with mask=1.
  - required: out_code=26 (91 mod 64 = 27, XOR 1) and out_range_err=1.
- Backpressure:
  - stimulus: x=2, out_ready=0 for 10 cycles, in_valid held high with a new word (x=3).
  - required: out_code=26 stays stable and in_ready=0 throughout.
  - required: x=3 is not accepted until the cycle after out_ready=1 completes the x=2 handshake.
  - required: back-to-back words complete one per 6 cycles.
- Reset mid-operation:
  - stimulus: rst=1 two cycles after accepting x=4, then a fresh x=1.
  - required: out_valid is never asserted for x=4.
  - required: one cycle after reset, out_code=0, out_range_err=0 and in_ready=1.
  - required: x=1 then yields 13.
- Decoder loopback: drive out_code into the A=13 decoder for every x in 0..4 and every single-bit mask.
  - required: the decoder q equals x in every case.
  - required: the decoder error flag is 0 when mask=0 and 1 when mask≠0.
